// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-side memory responder: word RAM, load/store lane steering, MMIO tohost/cycle/UART FIFO
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmemAddr,
    input  logic [31:0] dmemWdata,
    input  logic [2:0]  dmemSize,
    input  logic        dmemWen,
    output logic [31:0] dmemRdata,
    output logic [31:0] tohost,
    output logic        tohostValid,
    output logic        misalignErr,
    output logic [31:0] misalignAddr,
    output logic [7:0]  txData,
    output logic        txValid,
    input  logic        txReady
);
    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [4:0] OFF_TOHOST = 5'h00;
    localparam logic [4:0] OFF_CYC_LO = 5'h04;
    localparam logic [4:0] OFF_CYC_HI = 5'h08;
    localparam logic [4:0] OFF_UART   = 5'h0C;
    localparam logic [4:0] OFF_STAT   = 5'h10;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] tohost_q;
    logic        tohost_valid_q;
    logic        misalign_err_q;
    logic [31:0] misalign_addr_q;
    logic [63:0] cycle_q;
    logic [7:0]  fifo_q [4];
    logic [1:0]  head_q, tail_q;
    logic [2:0]  count_q, count_d;
    logic        overflow_q;

    logic [AW-1:0] word_idx;
    logic [4:0]    off;
    logic          in_ram, in_mmio;
    logic [31:0]   word, stat;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic          size_ok, misalign, store_ok;
    logic          push_req, pop, full, accept;

    assign word_idx = dmemAddr[AW+1:2];
    assign off      = dmemAddr[4:0];
    assign in_ram   = (dmemAddr[31:AW+2] == '0);
    assign in_mmio  = (dmemAddr[31:5] == MMIO_BASE[31:5]);
    assign stat     = {26'b0, count_q, overflow_q, (count_q == 3'd0), (count_q == 3'd4)};

    // Select the addressed 32-bit word from RAM or the MMIO register file
    always_comb begin
        word = 32'h0;
        if (in_ram) begin
            word = mem_q[word_idx];
        end else if (in_mmio) begin
            case (off)
                OFF_TOHOST: word = tohost_q;
                OFF_CYC_LO: word = cycle_q[31:0];
                OFF_CYC_HI: word = cycle_q[63:32];
                OFF_STAT:   word = stat;
                default:    word = 32'h0;
            endcase
        end
    end

    // Extract the lane and extend; misaligned halves/words read as zero
    always_comb begin
        rd_byte = word[8*dmemAddr[1:0] +: 8];
        rd_half = dmemAddr[1] ? word[31:16] : word[15:0];
        case (dmemSize)
            3'b000:  dmemRdata = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  dmemRdata = {24'b0, rd_byte};
            3'b001:  dmemRdata = dmemAddr[0] ? 32'h0 : {{16{rd_half[15]}}, rd_half};
            3'b101:  dmemRdata = dmemAddr[0] ? 32'h0 : {16'b0, rd_half};
            default: dmemRdata = (dmemAddr[1:0] == 2'b00) ? word : 32'h0;
        endcase
    end

    // Store decode: byte enables, replicated lane data, alignment qualification
    always_comb begin
        be      = 4'b0000;
        wlane   = dmemWdata;
        size_ok = 1'b0;
        case (dmemSize)
            3'b000: begin
                be      = 4'b0001 << dmemAddr[1:0];
                wlane   = {4{dmemWdata[7:0]}};
                size_ok = 1'b1;
            end
            3'b001: begin
                be      = dmemAddr[1] ? 4'b1100 : 4'b0011;
                wlane   = {2{dmemWdata[15:0]}};
                size_ok = 1'b1;
            end
            3'b010: begin
                be      = 4'b1111;
                size_ok = 1'b1;
            end
            default: ;
        endcase
        misalign = dmemWen && (((dmemSize == 3'b001) && dmemAddr[0]) ||
                               ((dmemSize == 3'b010) && (dmemAddr[1:0] != 2'b00)));
        store_ok = dmemWen && size_ok && !misalign;
    end

    assign full     = (count_q == 3'd4);
    assign txValid  = (count_q != 3'd0);
    assign txData   = txValid ? fifo_q[head_q] : 8'h00;
    assign pop      = txValid && txReady;
    assign push_req = store_ok && in_mmio && (off == OFF_UART);
    assign accept   = push_req && (!full || pop);

    // FIFO occupancy next state
    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 3'd1;
        else if (!accept && pop) count_d = count_q - 3'd1;
    end

    // RAM byte-lane writes; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (!rst && store_ok && in_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[word_idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    // FIFO storage; only the pointers and count need a reset
    always_ff @(posedge clk) begin
        if (!rst && accept) fifo_q[tail_q] <= dmemWdata[7:0];
    end

    // Control state: tohost, misalign capture, cycle counter, FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q        <= 32'h0;
            tohost_valid_q  <= 1'b0;
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= 32'h0;
            cycle_q         <= 64'h0;
            head_q          <= 2'd0;
            tail_q          <= 2'd0;
            count_q         <= 3'd0;
            overflow_q      <= 1'b0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (store_ok && in_mmio && (off == OFF_TOHOST) && (dmemSize == 3'b010)) begin
                tohost_q       <= dmemWdata;
                tohost_valid_q <= 1'b1;
            end
            if (misalign && !misalign_err_q) begin
                misalign_err_q  <= 1'b1;
                misalign_addr_q <= dmemAddr;
            end
            if (accept) tail_q <= tail_q + 2'd1;
            if (pop)    head_q <= head_q + 2'd1;
            if (push_req && full && !pop) overflow_q <= 1'b1;
            count_q <= count_d;
        end
    end

    assign tohost       = tohost_q;
    assign tohostValid  = tohost_valid_q;
    assign misalignErr  = misalign_err_q;
    assign misalignAddr = misalign_addr_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
`timescale 1ns/1ps
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmemAddr, dmemWdata, dmemRdata, tohost, misalignAddr;
    logic [2:0]  dmemSize;
    logic        dmemWen, tohostValid, misalignErr, txValid, txReady;
    logic [7:0]  txData;
    logic [31:0] rd;
    int          tests_run = 0;
    int          tests_failed = 0;

    localparam logic [31:0] TOHOST = 32'h8000_0000;
    localparam logic [31:0] CYC_LO = 32'h8000_0004;
    localparam logic [31:0] CYC_HI = 32'h8000_0008;
    localparam logic [31:0] UART   = 32'h8000_000C;
    localparam logic [31:0] STAT   = 32'h8000_0010;

    dmem_responder dut (
        .clk(clk), .rst(rst),
        .dmemAddr(dmemAddr), .dmemWdata(dmemWdata), .dmemSize(dmemSize), .dmemWen(dmemWen),
        .dmemRdata(dmemRdata), .tohost(tohost), .tohostValid(tohostValid),
        .misalignErr(misalignErr), .misalignAddr(misalignAddr),
        .txData(txData), .txValid(txValid), .txReady(txReady)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        dmemAddr  = a;
        dmemWdata = d;
        dmemSize  = sz;
        dmemWen   = 1'b1;
        tick();
        dmemWen   = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [2:0] sz, output logic [31:0] d);
        dmemWen  = 1'b0;
        dmemAddr = a;
        dmemSize = sz;
        #1;
        d = dmemRdata;
    endtask

    initial begin
        rst = 1'b1; dmemAddr = 0; dmemWdata = 0; dmemSize = 3'b010; dmemWen = 0; txReady = 0;
        tick(); tick();
        check("rst_tohost", tohost, 0);
        check("rst_tohost_valid", {31'b0, tohostValid}, 0);
        check("rst_misalign_err", {31'b0, misalignErr}, 0);
        check("rst_misalign_addr", misalignAddr, 0);
        check("rst_tx_valid", {31'b0, txValid}, 0);
        check("rst_tx_data", {24'b0, txData}, 0);
        ld(STAT, 3'b010, rd);  check("rst_stat", rd, 32'h02);
        rst = 1'b0;
        ld(CYC_LO, 3'b010, rd); check("cycle_0", rd, 0);
        tick();
        ld(CYC_LO, 3'b010, rd); check("cycle_1", rd, 1);
        repeat (4) tick();
        ld(CYC_LO, 3'b010, rd); check("cycle_5", rd, 5);
        ld(CYC_HI, 3'b010, rd); check("cycle_hi", rd, 0);

        // lane steering and extension
        st(32'h100, 32'h8081_7F01, 3'b010);
        st(32'h101, 32'h0000_00AA, 3'b000);
        ld(32'h100, 3'b010, rd); check("lw_100", rd, 32'h8081_AA01);
        ld(32'h101, 3'b000, rd); check("lb_101", rd, 32'hFFFF_FFAA);
        ld(32'h101, 3'b100, rd); check("lbu_101", rd, 32'h0000_00AA);
        ld(32'h102, 3'b001, rd); check("lh_102", rd, 32'hFFFF_8081);
        ld(32'h102, 3'b101, rd); check("lhu_102", rd, 32'h0000_8081);
        ld(32'h101, 3'b001, rd); check("lh_odd", rd, 0);

        // same-cycle load sees old data, next cycle new
        st(32'h200, 32'h0000_0001, 3'b010);
        dmemAddr = 32'h200; dmemWdata = 32'h0000_0002; dmemSize = 3'b010; dmemWen = 1'b1;
        #1; check("ld_during_store", dmemRdata, 1);
        tick(); dmemWen = 1'b0;
        ld(32'h200, 3'b010, rd); check("ld_after_store", rd, 2);

        // misaligned stores
        st(32'h100, 32'h1111_1111, 3'b010);
        st(32'h102, 32'hDEAD_BEEF, 3'b010);
        st(32'h105, 32'h0000_1234, 3'b001);
        ld(32'h100, 3'b010, rd); check("misal_ram", rd, 32'h1111_1111);
        check("misal_err", {31'b0, misalignErr}, 1);
        check("misal_addr", misalignAddr, 32'h102);
        ld(32'h103, 3'b010, rd); check("lw_misal", rd, 0);

        // tohost
        st(TOHOST, 32'h55, 3'b000);
        check("tohost_sb", {31'b0, tohostValid}, 0);
        st(TOHOST, 32'h1, 3'b010);
        check("tohost_val", tohost, 1);
        check("tohost_valid", {31'b0, tohostValid}, 1);
        repeat (10) tick();
        check("tohost_hold", tohost, 1);
        check("tohost_valid_hold", {31'b0, tohostValid}, 1);

        // fifo fill, overflow, drain
        for (int i = 0; i < 4; i++) st(UART, 32'h41 + i, 3'b000);
        ld(STAT, 3'b010, rd); check("stat_full", rd, 32'h21);
        st(UART, 32'h45, 3'b000);
        ld(STAT, 3'b010, rd); check("stat_ovf", rd, 32'h25);
        txReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain", {24'b0, txData}, 32'h41 + i);
            tick();
        end
        txReady = 1'b0;
        check("drain_empty", {31'b0, txValid}, 0);
        ld(STAT, 3'b010, rd); check("stat_drained", rd, 32'h06);

        // reset mid-operation; coincident store dropped
        st(UART, 32'h77, 3'b000);
        rst = 1'b1;
        st(32'h100, 32'h2222_2222, 3'b010);
        check("rst2_tohost", tohost, 0);
        check("rst2_tohost_valid", {31'b0, tohostValid}, 0);
        check("rst2_misal_err", {31'b0, misalignErr}, 0);
        check("rst2_misal_addr", misalignAddr, 0);
        check("rst2_tx_valid", {31'b0, txValid}, 0);
        check("rst2_tx_data", {24'b0, txData}, 0);
        ld(STAT, 3'b010, rd); check("rst2_stat", rd, 32'h02);
        ld(CYC_LO, 3'b010, rd); check("rst2_cycle", rd, 0);
        ld(32'h100, 3'b010, rd); check("rst2_store_dropped", rd, 32'h1111_1111);
        rst = 1'b0;

        // full fifo with simultaneous push and pop
        for (int i = 0; i < 4; i++) st(UART, 32'h41 + i, 3'b000);
        txReady = 1'b1;
        st(UART, 32'h45, 3'b000);
        txReady = 1'b0;
        ld(STAT, 3'b010, rd); check("stat_pushpop", rd, 32'h21);
        txReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain2", {24'b0, txData}, 32'h42 + i);
            tick();
        end
        txReady = 1'b0;
        check("drain2_empty", {31'b0, txValid}, 0);
        ld(STAT, 3'b010, rd); check("stat_end", rd, 32'h02);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
